// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared definitions for the data-memory unit.
//   * access-size encodings (SZ_WORD / SZ_BYTE)
//   * FSM state encoding used by dmem_unit
//   * default geometry / latency parameters
//   * helpers for byte-lane enables and load-data extraction
package dmem_pkg;

  localparam int DEF_DEPTH_WORDS = 1024;
  localparam int DEF_LAT         = 2;

  localparam logic SZ_WORD = 1'b0;
  localparam logic SZ_BYTE = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Byte-enable mask for a store: a byte access touches only the lane
  // selected by the low address bits (little-endian), a word touches all.
  function automatic logic [3:0] lane_enables(input logic sz, input logic [1:0] off);
    if (sz == SZ_BYTE) return 4'b0001 << off;
    return 4'b1111;
  endfunction

  // Shape a raw memory word into the load result: byte loads are
  // zero-extended, sign extension happens later in register writeback.
  function automatic logic [31:0] load_extract(input logic sz, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [31:0] shifted;
    shifted = word >> {off, 3'b000};
    if (sz == SZ_BYTE) return {24'd0, shifted[7:0]};
    return word;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram -- single-port synchronous storage, 32-bit words split into
// four independently writable byte lanes, registered read.
// Ports:
//   clk     : clock, all accesses on the rising edge
//   we_i    : write strobe
//   re_i    : read strobe; rdata_o updates only when asserted
//   be_i    : per-lane byte enables (bit 0 = bits 7:0)
//   addr_i  : word index
//   wdata_i : write data (lane n taken from bits 8n+7:8n)
//   rdata_o : registered read data
// Contents start at zero and are never cleared afterwards.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS
) (
  input  logic                           clk,
  input  logic                           we_i,
  input  logic                           re_i,
  input  logic [3:0]                     be_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]                    wdata_i,
  output logic [31:0]                    rdata_o
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      // One narrow array per lane so each maps onto its own RAM column.
      logic [7:0] mem_q [DEPTH_WORDS] = '{default: 8'h00};
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
        if (we_i && be_i[gi]) begin
          mem_q[addr_i] <= wdata_i[8*gi +: 8];
        end
        if (re_i) begin
          rd_q <= mem_q[addr_i];
        end
      end

      assign rdata_o[8*gi +: 8] = rd_q;
    end
  endgenerate

endmodule

// File: rtl/dmem_unit.sv
// dmem_unit -- fixed-latency data-memory unit (IDLE -> WAIT -> RESP).
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset
//   req   : access request, sampled only in IDLE
//   we    : 1 = store, 0 = load
//   size  : SZ_WORD / SZ_BYTE
//   addr  : byte address (wraps modulo memory size)
//   wdata : store data (byte stores use bits 7:0)
//   rdata : load result, non-zero only while ready
//   ready : one-cycle response strobe
//   busy  : high in WAIT and RESP
//   err   : misaligned word access flag, only while ready
module dmem_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int LAT         = DEF_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic        size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic          size_q, size_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          commit;
  logic          misalign;
  logic          ram_we;
  logic          ram_re;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic          resp_load;

  // Address bits above the memory size alias onto the same words.
  logic          addr_unused;
  assign addr_unused = ^addr[31:AW+2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          addr_d  = addr[AW+1:0];
          wdata_d = wdata;
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The counter runs LAT-1 .. 0, so WAIT lasts exactly LAT cycles.
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= SZ_WORD;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // The WAIT->RESP edge is the only edge that touches memory. Gating with
  // rst guarantees a store aborted on that very edge never lands.
  assign commit   = (state_q == ST_WAIT) && (cnt_q == 4'd0) && !rst;
  assign misalign = (size_q == SZ_WORD) && (addr_q[1:0] != 2'b00);

  assign ram_we    = commit && we_q && !misalign;
  assign ram_re    = commit && !we_q && !misalign;
  assign ram_be    = lane_enables(size_q, addr_q[1:0]);
  // Replicating the byte onto every lane lets the byte enable pick the lane.
  assign ram_wdata = (size_q == SZ_BYTE) ? {4{wdata_q[7:0]}} : wdata_q;

  dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .be_i    (ram_be),
    .addr_i  (addr_q[AW+1:2]),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign resp_load = (state_q == ST_RESP) && !we_q && !misalign;

  assign ready = (state_q == ST_RESP);
  assign busy  = (state_q != ST_IDLE);
  assign err   = ready && misalign;
  assign rdata = resp_load ? load_extract(size_q, addr_q[1:0], ram_rdata) : 32'd0;

endmodule
